// File: rtl/routing_table_mp.sv
// ID-routed CQ-to-downstream router: per-port bus windows programmed over cfg_ext, Type-1 to Type-0
// conversion at the target's secondary bus, skid-buffered output, unroutable packets dropped and counted.
module routing_table_mp #(
    parameter int TDATA_WIDTH    = 128,
    parameter int TKEEP_WIDTH    = 4,
    parameter int CQ_TUSER_WIDTH = 108,
    parameter int RQ_TUSER_WIDTH = 85,
    parameter int NUM_PORTS      = 4,
    parameter int DEST_WIDTH     = 3
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [TDATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [TKEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic                      s_axis_tlast,
    input  logic [CQ_TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [TDATA_WIDTH-1:0]    m_axis_tdata,
    output logic [TKEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic [RQ_TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                      m_axis_tvalid,
    output logic [DEST_WIDTH-1:0]     m_axis_tdest,
    input  logic                      m_axis_tready,
    input  logic                      cfg_ext_read_received,
    input  logic                      cfg_ext_write_received,
    input  logic [9:0]                cfg_ext_register_number,
    input  logic [7:0]                cfg_ext_function_number,
    input  logic [31:0]               cfg_ext_write_data,
    input  logic [3:0]                cfg_ext_write_byte_enable,
    output logic [31:0]               cfg_ext_read_data,
    output logic                      cfg_ext_read_data_valid,
    output logic                      err_unrouted
);

    localparam int PL_W = DEST_WIDTH + RQ_TUSER_WIDTH + 1 + TKEEP_WIDTH + TDATA_WIDTH;

    logic [7:0]           r_primary, r_secondary, r_subordinate;
    logic [7:0]           r_port_sec [NUM_PORTS];
    logic [7:0]           r_port_sub [NUM_PORTS];
    logic [NUM_PORTS-1:0] r_port_en;
    logic [15:0]          r_drop_cnt;
    logic [31:0]          r_rd_data;
    logic                 r_rd_vld;

    logic                  r_in_pkt, r_hit, r_err, r_s_tready;
    logic [DEST_WIDTH-1:0] r_dest;
    logic [PL_W-1:0]       r_out_pl, r_sk_pl;
    logic                  r_out_vld, r_sk_vld;

    logic [7:0]             w_bus;
    logic [3:0]             w_req_type;
    logic                   w_hit, w_at_sec, w_conv;
    logic [DEST_WIDTH-1:0]  w_dest, w_beat_dest;
    logic                   w_acc, w_sop, w_beat_hit, w_push, w_pop, w_miss_sop, w_sk_vld_nxt;
    logic [TDATA_WIDTH-1:0] w_in_data;
    logic [RQ_TUSER_WIDTH-1:0] w_rq_user;
    logic [PL_W-1:0]        w_in_pl;
    logic [31:0]            w_rd_mux;
    logic                   w_drop_clr;
    logic                   w_unused;

    assign w_unused = ^{cfg_ext_function_number, s_axis_tuser[52:42], s_axis_tuser[39:8],
                        cfg_ext_write_data[30:24]};

    assign w_bus      = s_axis_tdata[119:112];
    assign w_req_type = s_axis_tdata[78:75];
    assign w_sop      = s_axis_tuser[40];
    assign w_acc      = s_axis_tvalid && r_s_tready;
    assign w_pop      = r_out_vld && m_axis_tready;

    // Lowest-index enabled window wins: scan downward so lower k overrides.
    always_comb begin
        w_hit    = 1'b0;
        w_at_sec = 1'b0;
        w_dest   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (r_port_en[k] && (w_bus >= r_port_sec[k]) && (w_bus <= r_port_sub[k])) begin
                w_hit    = 1'b1;
                w_at_sec = (w_bus == r_port_sec[k]);
                w_dest   = DEST_WIDTH'(k);
            end
        end
    end

    assign w_conv      = w_hit && w_at_sec && (w_req_type[3:1] == 3'b101);
    assign w_beat_hit  = w_sop ? w_hit  : (r_in_pkt && r_hit);
    assign w_beat_dest = w_sop ? w_dest : r_dest;
    assign w_push      = w_acc && w_beat_hit;
    assign w_miss_sop  = w_acc && w_sop && !w_hit;

    always_comb begin
        w_in_data = s_axis_tdata;
        if (w_sop && w_conv) begin
            w_in_data[76] = 1'b0;
        end
    end

    assign w_rq_user = RQ_TUSER_WIDTH'({s_axis_tuser[107:53], 16'h0000, s_axis_tuser[41],
                                        3'b000, s_axis_tuser[7:0]});
    assign w_in_pl   = {w_beat_dest, w_rq_user, s_axis_tlast, s_axis_tkeep, w_in_data};

    assign w_sk_vld_nxt = r_sk_vld ? !w_pop : (w_push && r_out_vld && !w_pop);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_in_pkt   <= 1'b0;
            r_hit      <= 1'b0;
            r_dest     <= '0;
            r_err      <= 1'b0;
            r_s_tready <= 1'b0;
            r_out_pl   <= '0;
            r_out_vld  <= 1'b0;
            r_sk_pl    <= '0;
            r_sk_vld   <= 1'b0;
        end else begin
            r_err <= w_miss_sop;
            if (w_acc) begin
                if (w_sop) begin
                    r_hit  <= w_hit;
                    r_dest <= w_dest;
                end
                r_in_pkt <= !s_axis_tlast && (w_sop || r_in_pkt);
            end
            // Skid: output register holds still under stall, overflow beat parks in r_sk_pl.
            if (r_sk_vld) begin
                if (w_pop) begin
                    r_out_pl <= r_sk_pl;
                end
            end else if (w_push) begin
                if (!r_out_vld || w_pop) begin
                    r_out_pl  <= w_in_pl;
                    r_out_vld <= 1'b1;
                end else begin
                    r_sk_pl <= w_in_pl;
                end
            end else if (w_pop) begin
                r_out_vld <= 1'b0;
            end
            r_sk_vld   <= w_sk_vld_nxt;
            r_s_tready <= !w_sk_vld_nxt;
        end
    end

    always_comb begin
        w_rd_mux = '0;
        if (cfg_ext_register_number == 10'h006) begin
            w_rd_mux = {8'h00, r_subordinate, r_secondary, r_primary};
        end else if (cfg_ext_register_number == 10'h00F) begin
            w_rd_mux = {16'h0000, r_drop_cnt};
        end
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (cfg_ext_register_number == 10'h010 + 10'(k)) begin
                w_rd_mux = {r_port_en[k], 15'h0000, r_port_sub[k], r_port_sec[k]};
            end
        end
    end

    assign w_drop_clr = cfg_ext_write_received && (cfg_ext_register_number == 10'h00F) &&
                        cfg_ext_write_byte_enable[0];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_primary     <= '0;
            r_secondary   <= '0;
            r_subordinate <= '0;
            r_port_en     <= '0;
            r_drop_cnt    <= '0;
            r_rd_data     <= '0;
            r_rd_vld      <= 1'b0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                r_port_sec[k] <= '0;
                r_port_sub[k] <= '0;
            end
        end else begin
            if (cfg_ext_write_received && cfg_ext_register_number == 10'h006) begin
                if (cfg_ext_write_byte_enable[0]) r_primary     <= cfg_ext_write_data[7:0];
                if (cfg_ext_write_byte_enable[1]) r_secondary   <= cfg_ext_write_data[15:8];
                if (cfg_ext_write_byte_enable[2]) r_subordinate <= cfg_ext_write_data[23:16];
            end
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (cfg_ext_write_received && cfg_ext_register_number == 10'h010 + 10'(k)) begin
                    if (cfg_ext_write_byte_enable[0]) r_port_sec[k] <= cfg_ext_write_data[7:0];
                    if (cfg_ext_write_byte_enable[1]) r_port_sub[k] <= cfg_ext_write_data[15:8];
                    if (cfg_ext_write_byte_enable[3]) r_port_en[k]  <= cfg_ext_write_data[31];
                end
            end
            if (w_drop_clr) begin
                r_drop_cnt <= '0;
            end else if (w_miss_sop && r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            r_rd_vld  <= cfg_ext_read_received;
            r_rd_data <= cfg_ext_read_received ? w_rd_mux : 32'h0;
        end
    end

    assign s_axis_tready           = r_s_tready;
    assign m_axis_tdata            = r_out_pl[TDATA_WIDTH-1:0];
    assign m_axis_tkeep            = r_out_pl[TDATA_WIDTH +: TKEEP_WIDTH];
    assign m_axis_tlast            = r_out_pl[TDATA_WIDTH + TKEEP_WIDTH];
    assign m_axis_tuser            = r_out_pl[TDATA_WIDTH + TKEEP_WIDTH + 1 +: RQ_TUSER_WIDTH];
    assign m_axis_tdest            = r_out_pl[PL_W-1 -: DEST_WIDTH];
    assign m_axis_tvalid           = r_out_vld;
    assign err_unrouted            = r_err;
    assign cfg_ext_read_data       = r_rd_data;
    assign cfg_ext_read_data_valid = r_rd_vld;

endmodule

// File: doc/routing_table_mp.md
Name: routing_table_mp

Overview:
- Multi-port successor to the single-downstream-pair router in the PCIe virtual bridge.
- Routes CQ-side TLPs, ID-routed by the bus number in the descriptor, to one of NUM_PORTS downstream ports. It converts Type-1 config requests to Type-0 at the target port's secondary bus.
- Per-port bus windows are programmed through the cfg_ext interface.
- Output is registered through a skid buffer for full throughput; unroutable packets are dropped and counted.

Parameters:
- TDATA_WIDTH, 128, stream data width; minimum 128.
- TKEEP_WIDTH, 4, dword keep width.
- CQ_TUSER_WIDTH, 108, input tuser width.
- RQ_TUSER_WIDTH, 85, output tuser width.
- NUM_PORTS, 4, downstream ports; 1..8.
- DEST_WIDTH, 3, m_axis_tdest width; must satisfy 2^DEST_WIDTH >= NUM_PORTS.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_tdata/tkeep/tlast/tuser/tvalid  in  TDATA/TKEEP/1/CQ_TUSER/1  CQ stream
- s_axis_tready  out  1  CQ backpressure
- m_axis_tdata/tkeep/tlast/tuser/tvalid  out  TDATA/TKEEP/1/RQ_TUSER/1  routed stream
- m_axis_tdest  out  DEST_WIDTH  destination port index
- m_axis_tready  in  1  downstream backpressure
- cfg_ext_read_received, cfg_ext_write_received  in  1 each
- cfg_ext_register_number  in  10
- cfg_ext_function_number  in  8  (ignored)
- cfg_ext_write_data  in  32
- cfg_ext_write_byte_enable  in  4
- cfg_ext_read_data  out  32
- cfg_ext_read_data_valid  out  1
- err_unrouted  out  1  one-cycle pulse per dropped packet

Behaviour:
- Config registers, all reset to 0:
  - Reg 0x006: primary[7:0], secondary[15:8], subordinate[23:16]; byte-enable gated.
  - Reg 0x010+k, for k < NUM_PORTS: port_sec[7:0], port_sub[15:8], port_en[31]; byte-enable gated.
  - Reg 0x00F: drop_count[15:0], read-only. A write of any value with be[0] set clears it.
  - Writes to other registers are ignored.
- Config reads:
  - cfg_ext_read_data and cfg_ext_read_data_valid are registered and asserted exactly 1 cycle after cfg_ext_read_received.
  - Unmapped registers read 0. Valid is low otherwise.
- Input decode:
  - An accepted beat is one with s_axis_tvalid && s_axis_tready.
  - SOP is an accepted beat with s_axis_tuser[40] = 1.
  - bus = tdata[119:112]; req_type = tdata[78:75].
- Routing decision, evaluated only on SOP:
  - Target is the lowest k with port_en[k] && port_sec[k] <= bus <= port_sub[k].
  - Decision uses config values registered before the SOP cycle; a same-cycle config write affects the next SOP only.
  - Decision (dest, hit, convert) is latched and applied to every beat through tlast.
  - A packet that is SOP and tlast on the same beat uses its own decision.
- Type-1 to Type-0 conversion:
  - Applies on a hit with req_type in {1010, 1011} and bus == port_sec[k].
  - Clears tdata[76] on the SOP beat only. All other bits pass unmodified.
- Miss handling:
  - On a miss (no enabled window), all beats through tlast are consumed with s_axis_tready = 1 and never presented on m_axis.
  - err_unrouted pulses for 1 cycle on the SOP beat.
  - drop_count increments and saturates at 0xFFFF.
- tuser remap:
  - m_axis_tuser = zero-extend {tuser[107:53], 16'h0, tuser[41], 3'b0, tuser[7:0]} to RQ_TUSER_WIDTH.
- Output stage:
  - A 2-entry skid buffer gives 1-cycle latency and 1 beat/cycle throughput under continuous m_axis_tready.
  - s_axis_tready = skid entry free, registered; it does not combinationally depend on m_axis_tready.
  - m_axis_* are stable while tvalid && !tready.
- Reset:
  - All state clears asynchronously: m_axis_tvalid = 0, m_axis_tdest = 0, m_axis data/tuser/tkeep/tlast = 0, s_axis_tready = 0, err_unrouted = 0, cfg_ext_read_data = 0, cfg_ext_read_data_valid = 0.
  - s_axis_tready rises on the first clock after release.
  - A packet interrupted by reset is discarded. The next beat with tuser[40] = 1 is treated as SOP; beats without SOP before it are dropped without counting.

Test Plan:
- Write reg 0x010 = 0x8000_0302 (port0 window 2..3) and 0x011 = 0x8000_0704 (port1 window 4..7). A 3-beat SOP with bus = 5 -> all beats leave with tdest = 1 one cycle later; tdata unchanged.
- Type-1 cfg write (req_type = 1011) to bus = 2 -> tdest = 0 and out tdata[78:75] = 1001. The same TLP to bus = 3 -> tdest = 0, tdata[78:75] = 1011 unchanged.
- bus = 9 with the windows above -> no m_axis beats, err_unrouted pulses once, reg 0x00F reads 0x0000_0001 with read_data_valid exactly 1 cycle after read_received.
- Overlapping windows (port0 0..7, port1 4..7) with bus = 5 -> tdest = 0. Clearing port0_en -> next SOP tdest = 1. A window change mid-packet does not change tdest of remaining beats.
- Random m_axis_tready toggling over 1000 packets -> no data loss or duplication, output stable while stalled. With tready held at 1, throughput is 1 beat/cycle after the first.
- Assert aresetn low mid-packet -> all outputs 0 immediately. After release, trailing beats without SOP are dropped and the next SOP routes correctly.
